line_mem_responder: RTL and testbench

- Responder end of the cache-line memory port driven by the I/D caches and atomic unit (strobe/addr/rw/line-data/done handshake).
- Serves each CLSIZE-bit line request by serialising it into XLEN-bit word accesses on a single-port synchronous on-chip SRAM.
- Returns one done pulse per request and, for reads, a full assembled line.
- Used as a DDR stand-in in TCM-only SoC builds and as the memory model for cache verification.

---
 rtl/line_mem_pkg.sv | 22 ++
 rtl/line_mem_responder.sv | 127 ++++++++++++
 tb/tb_line_mem_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared constants and state
// encoding for the line memory responder.
package line_mem_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CLSIZE_DEF = 256;
  localparam int MEM_AW_DEF = 14;

  localparam int BEATS      = CLSIZE_DEF / XLEN_DEF;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LINE_OFS_W = $clog2(CLSIZE_DEF / 8);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_LAST,
    DONE,
    WAIT_LOW
  } lm_state_e;

endpackage

// File: rtl/line_mem_responder.sv
// line_mem_responder: serialises cache-line
// requests into word accesses on an SRAM port.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CLSIZE = CLSIZE_DEF,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              strobe_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              rw_i,
  input  logic [CLSIZE-1:0] data_i,
  output logic              done_o,
  output logic [CLSIZE-1:0] data_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int NB   = CLSIZE / XLEN;
  localparam int NBW  = $clog2(NB);
  localparam int WOFS = $clog2(XLEN / 8);

  lm_state_e         state_q;
  lm_state_e         state_d;
  logic [NBW-1:0]    beat_q;
  logic [MEM_AW-1:0] base_q;
  logic [CLSIZE-1:0] wline_q;
  logic [CLSIZE-1:0] rbuf_q;

  logic              accept;
  logic              last_beat;
  logic              capture;
  logic [NBW-1:0]    slot;
  logic [MEM_AW-1:0] beat_addr;
  logic [XLEN-1:0]   beat_word;
  logic              unused_addr;

  assign accept    = (state_q == IDLE) && strobe_i;
  assign last_beat = (beat_q == NBW'(NB - 1));
  // read data lags its issue by one cycle;
  // the counter wraps to 0 after the last
  // issue, so beat-1 is always the slot
  assign capture   = ((state_q == RD) && (beat_q != '0))
                  || (state_q == RD_LAST);
  assign slot      = beat_q - NBW'(1);
  assign beat_addr = base_q + MEM_AW'(beat_q);
  assign beat_word = wline_q[beat_q*XLEN +: XLEN];
  assign data_o    = rbuf_q;

  assign unused_addr = ^{addr_i[XLEN-1:MEM_AW+WOFS],
                         addr_i[WOFS+NBW-1:0]};

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (strobe_i) state_d = rw_i ? WR : RD;
      WR:       if (last_beat) state_d = DONE;
      RD:       if (last_beat) state_d = RD_LAST;
      RD_LAST:  state_d = DONE;
      DONE:     state_d = WAIT_LOW;
      WAIT_LOW: if (!strobe_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // SRAM strobes and completion pulse
  always_comb begin
    done_o      = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      (state_q == WR): begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = beat_addr;
        mem_wdata_o = beat_word;
      end
      (state_q == RD): begin
        mem_en_o   = 1'b1;
        mem_addr_o = beat_addr;
      end
      (state_q == DONE): done_o = 1'b1;
      default: ;
    endcase
  end

  // request latch and beat counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q  <= '0;
      wline_q <= '0;
      beat_q  <= '0;
    end else if (accept) begin
      base_q  <= {addr_i[MEM_AW+WOFS-1:WOFS+NBW],
                  {NBW{1'b0}}};
      wline_q <= data_i;
      beat_q  <= '0;
    end else if (state_q == WR || state_q == RD) begin
      beat_q  <= beat_q + NBW'(1);
    end
  end

  // read line assembly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rbuf_q <= '0;
    end else if (capture) begin
      rbuf_q[slot*XLEN +: XLEN] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: scoreboard bench for
// the line memory responder with an SRAM model.
module tb_line_mem_responder;
  import line_mem_pkg::*;

  localparam int XL = XLEN_DEF;
  localparam int CL = CLSIZE_DEF;
  localparam int AW = MEM_AW_DEF;
  localparam int WO = $clog2(XL / 8);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          strobe = 1'b0;
  logic [XL-1:0] addr = '0;
  logic          rw = 1'b0;
  logic [CL-1:0] wdata = '0;
  logic          done;
  logic [CL-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [XL-1:0] mem_wdata;
  logic [XL-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .strobe_i    (strobe),
    .addr_i      (addr),
    .rw_i        (rw),
    .data_i      (wdata),
    .done_o      (done),
    .data_o      (rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  logic [XL-1:0] sram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [XL-1:0] wd;
  } beat_t;

  typedef struct {
    int            cyc;
    logic [CL-1:0] line;
  } resp_t;

  beat_t         beat_q[$];
  resp_t         resp_q[$];
  logic [XL-1:0] ref_mem [0:(1<<AW)-1];
  logic [CL-1:0] last_rd = '0;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            ndone = 0;

  task automatic chk(input string tag,
                     input logic [CL-1:0] got,
                     input logic [CL-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    resp_t r;
    if (rst_n) begin
      if (mem_en) begin
        if (beat_q.size() == 0) begin
          chk("stray_beat", CL'(1), CL'(0));
        end else begin
          b = beat_q.pop_front();
          chk("mem_addr", CL'(mem_addr), CL'(b.a));
          chk("mem_we", CL'(mem_we), CL'(b.we));
          chk("mem_wdata", CL'(mem_wdata), CL'(b.wd));
        end
      end else begin
        if (mem_we || mem_wdata != '0)
          chk("idle_bus", CL'({mem_we, mem_wdata}), CL'(0));
      end
      if (done) begin
        ndone++;
        if (resp_q.size() == 0) begin
          chk("stray_done", CL'(1), CL'(0));
        end else begin
          r = resp_q.pop_front();
          chk("done_cyc", CL'(cyc), CL'(r.cyc));
          chk("data_o", rdata, r.line);
        end
      end
    end
  end

  task automatic push_exp(input logic w,
                          input logic [XL-1:0] a,
                          input logic [CL-1:0] d);
    logic [XL-1:0] wi;
    logic [AW-1:0] base;
    logic [AW-1:0] ba;
    logic [CL-1:0] line;
    resp_t         r;
    wi   = a >> WO;
    base = wi[AW-1:0] & ~AW'(BEATS - 1);
    line = '0;
    for (int i = 0; i < BEATS; i++) begin
      ba = base + AW'(i);
      if (w) begin
        ref_mem[ba] = d[i*XL +: XL];
        beat_q.push_back('{ba, 1'b1, d[i*XL +: XL]});
      end else begin
        line[i*XL +: XL] = ref_mem[ba];
        beat_q.push_back('{ba, 1'b0, '0});
      end
    end
    if (!w) last_rd = line;
    r.cyc  = cyc + (w ? BEATS + 1 : BEATS + 2);
    r.line = last_rd;
    resp_q.push_back(r);
  endtask

  task automatic req(input logic w,
                     input logic [XL-1:0] a,
                     input logic [CL-1:0] d,
                     input int hold);
    int n0;
    int k;
    push_exp(w, a, d);
    n0     = ndone;
    strobe = 1'b1;
    rw     = w;
    addr   = a;
    wdata  = d;
    @(negedge clk);
    if (hold == 0) strobe = 1'b0;
    rw    = ~w;
    addr  = ~a;
    wdata = ~d;
    k = 0;
    while (ndone == n0 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (ndone == n0) chk("timeout", CL'(0), CL'(1));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      strobe = 1'b0;
      chk("held_once", CL'(ndone - n0), CL'(1));
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [CL-1:0] rnd_line();
    logic [CL-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*XL +: XL] = $urandom;
    return l;
  endfunction

  logic [CL-1:0] l1;
  logic [CL-1:0] l2;
  int            n0;

  initial begin
    for (int i = 0; i < BEATS; i++)
      l1[i*XL +: XL] = 32'h1111_1111 * (i + 1);
    repeat (3) @(negedge clk);
    chk("rst_done", CL'(done), CL'(0));
    chk("rst_en", CL'(mem_en), CL'(0));
    chk("rst_we", CL'(mem_we), CL'(0));
    chk("rst_addr", CL'(mem_addr), CL'(0));
    chk("rst_wdata", CL'(mem_wdata), CL'(0));
    chk("rst_data", rdata, CL'(0));
    rst_n = 1'b1;
    @(negedge clk);

    req(1'b1, 32'h8000_0040, l1, 0);
    req(1'b0, 32'h8000_0040, '0, 0);
    req(1'b0, 32'h8000_005C, '0, 0);

    l2 = rnd_line();
    req(1'b1, 32'h8001_0000, l2, 0);
    req(1'b0, 32'h8001_0000, '0, 0);
    req(1'b1, 32'h8000_0080, rnd_line(), 0);

    req(1'b0, 32'h8000_0040, '0, 3);

    push_exp(1'b0, 32'h8000_0040, '0);
    n0     = ndone;
    strobe = 1'b1;
    rw     = 1'b0;
    addr   = 32'h8000_0040;
    @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_done", CL'(done), CL'(0));
    chk("mid_en", CL'(mem_en), CL'(0));
    chk("mid_we", CL'(mem_we), CL'(0));
    chk("mid_addr", CL'(mem_addr), CL'(0));
    chk("mid_wdata", CL'(mem_wdata), CL'(0));
    chk("mid_data", rdata, CL'(0));
    beat_q.delete();
    resp_q.delete();
    last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_nodone", CL'(ndone - n0), CL'(0));

    req(1'b0, 32'h8000_0040, '0, 0);
    for (int i = 0; i < 4; i++) begin
      addr = {16'h8000, 4'h0, 7'($urandom_range(0, 127)), 5'h0};
      l2   = rnd_line();
      req(1'b1, addr, l2, 0);
      req(1'b0, addr, '0, 0);
    end

    repeat (4) @(negedge clk);
    chk("beats_left", CL'(beat_q.size()), CL'(0));
    chk("resp_left", CL'(resp_q.size()), CL'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
